// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, aluop classes,
// R-type {fun7,fun3} keys and the FSM state type.
package alu_pkg;

    // Decoded control codes
    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_OR      = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_XOR     = 4'b0011;
    localparam logic [3:0] CTRL_SLL     = 4'b0100;
    localparam logic [3:0] CTRL_SRL     = 4'b0101;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_SLT     = 4'b0111;
    localparam logic [3:0] CTRL_SRA     = 4'b1000;
    localparam logic [3:0] CTRL_SLTU    = 4'b1001;
    localparam logic [3:0] CTRL_MUL     = 4'b1010;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    // aluop classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    // R-type decode keys, laid out as {fun7, fun3}
    localparam logic [9:0] RT_ADD  = {7'b0000000, 3'b000};
    localparam logic [9:0] RT_SUB  = {7'b0100000, 3'b000};
    localparam logic [9:0] RT_AND  = {7'b0000000, 3'b111};
    localparam logic [9:0] RT_OR   = {7'b0000000, 3'b110};
    localparam logic [9:0] RT_XOR  = {7'b0000000, 3'b100};
    localparam logic [9:0] RT_SLL  = {7'b0000000, 3'b001};
    localparam logic [9:0] RT_SRL  = {7'b0000000, 3'b101};
    localparam logic [9:0] RT_SRA  = {7'b0100000, 3'b101};
    localparam logic [9:0] RT_SLT  = {7'b0000000, 3'b010};
    localparam logic [9:0] RT_SLTU = {7'b0000000, 3'b011};
    localparam logic [9:0] RT_MUL  = {7'b0000001, 3'b000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Extracts the {fun7, fun3} key from an instruction word
    function automatic logic [9:0] rtype_key(input logic [31:0] instr);
        return {instr[31:25], instr[14:12]};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of (aluop, instruction) into the 4-bit ALU control.
// The multiply encoding decodes as mul only when ALU_SEQ_MUL_EN is defined;
// otherwise it falls through to illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0]  aluop,
    input  logic [31:0] instruction,
    output logic [3:0]  control
);

    logic [9:0] key_s;
    logic       unused_instr_s;

    assign key_s          = rtype_key(instruction);
    // Only fun7/fun3 participate in the decode
    assign unused_instr_s = ^{instruction[24:15], instruction[11:0]};

    // Map aluop class and R-type key to a control code
    always_comb begin
        control = CTRL_ILLEGAL;
        case (aluop)
            ALUOP_ADD: control = CTRL_ADD;
            ALUOP_SUB: control = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (key_s)
                    RT_ADD:  control = CTRL_ADD;
                    RT_SUB:  control = CTRL_SUB;
                    RT_AND:  control = CTRL_AND;
                    RT_OR:   control = CTRL_OR;
                    RT_XOR:  control = CTRL_XOR;
                    RT_SLL:  control = CTRL_SLL;
                    RT_SRL:  control = CTRL_SRL;
                    RT_SRA:  control = CTRL_SRA;
                    RT_SLT:  control = CTRL_SLT;
                    RT_SLTU: control = CTRL_SLTU;
`ifdef ALU_SEQ_MUL_EN
                    RT_MUL:  control = CTRL_MUL;
`endif
                    default: control = CTRL_ILLEGAL;
                endcase
            end
            ALUOP_ILL: control = CTRL_ILLEGAL;
            default:   control = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete in one cycle; with ALU_SEQ_MUL_EN defined, mul
// runs as an XLEN-step shift-add loop in the EXEC state. All outputs are
// registered and held while a result waits for out_ready.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [1:0]      aluop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      control,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      control_q, control_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic [3:0]      dec_ctrl_s;
    logic [XLEN-1:0] alu_res_s;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_sum_s;
`endif

    alu_decode u_decode (
        .aluop       (aluop),
        .instruction (instruction),
        .control     (dec_ctrl_s)
    );

    // Single-cycle result for a given control code; anything else yields 0
    function automatic logic [XLEN-1:0] alu_compute(
        input logic [3:0]      ctrl,
        input logic [XLEN-1:0] op_a,
        input logic [XLEN-1:0] op_b
    );
        logic [SHW-1:0]  shamt;
        logic [XLEN-1:0] res;
        shamt = op_b[SHW-1:0];
        case (ctrl)
            CTRL_AND:  res = op_a & op_b;
            CTRL_OR:   res = op_a | op_b;
            CTRL_ADD:  res = op_a + op_b;
            CTRL_XOR:  res = op_a ^ op_b;
            CTRL_SLL:  res = op_a << shamt;
            CTRL_SRL:  res = op_a >> shamt;
            CTRL_SUB:  res = op_a - op_b;
            CTRL_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTRL_SRA:  res = $unsigned($signed(op_a) >>> shamt);
            CTRL_SLTU: res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:   res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

    assign alu_res_s = alu_compute(dec_ctrl_s, a, b);

`ifdef ALU_SEQ_MUL_EN
    // Partial product after adding the current multiplicand when the low multiplier bit is set
    assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : {XLEN{1'b0}});
`endif

    // Next-state and next-output logic for the IDLE/EXEC/DONE controller
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        control_d = control_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (dec_ctrl_s == CTRL_MUL) begin
                        state_d   = ST_EXEC;
                        control_d = CTRL_MUL;
                        illegal_d = 1'b0;
                        acc_d     = {XLEN{1'b0}};
                        mcand_d   = a;
                        mplier_d  = b;
                        cnt_d     = {SHW{1'b0}};
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = alu_res_s;
                        control_d = dec_ctrl_s;
                        zero_d    = (alu_res_s == {XLEN{1'b0}});
                        illegal_d = (dec_ctrl_s == CTRL_ILLEGAL);
                    end
`else
                    state_d   = ST_DONE;
                    result_d  = alu_res_s;
                    control_d = dec_ctrl_s;
                    zero_d    = (alu_res_s == {XLEN{1'b0}});
                    illegal_d = (dec_ctrl_s == CTRL_ILLEGAL);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_EXEC: begin
                acc_d    = acc_sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    result_d = acc_sum_s;
                    zero_d   = (acc_sum_s == {XLEN{1'b0}});
                    cnt_d    = {SHW{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= {XLEN{1'b0}};
            control_q   <= 4'b0000;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= {XLEN{1'b0}};
            mcand_q     <= {XLEN{1'b0}};
            mplier_q    <= {XLEN{1'b0}};
            cnt_q       <= {SHW{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            control_q   <= control_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign control   = control_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
